// File: rtl/cnn_sdiv_seq_22s_14s_pkg.sv
// Shared constants, FSM state encoding and sign helpers for the 22/14-bit
// sequential signed divider.
package cnn_sdiv_seq_22s_14s_pkg;

  localparam int         DIN0_W  = 22;
  localparam int         DIN1_W  = 14;
  localparam int         PREM_W  = 15;
  localparam logic [4:0] ITERS   = 5'd22;
  localparam int         LATENCY = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [DIN0_W-1:0] cneg22(input logic [DIN0_W-1:0] v, input logic neg);
    cneg22 = neg ? (~v + 22'd1) : v;
  endfunction

  function automatic logic [DIN1_W-1:0] cneg14(input logic [DIN1_W-1:0] v, input logic neg);
    cneg14 = neg ? (~v + 14'd1) : v;
  endfunction

endpackage

// File: rtl/cnn_sdiv_seq_22s_14s_step.sv
// One unsigned restoring-division iteration: shift in the next dividend bit,
// subtract the divisor when it fits.
module cnn_sdiv_seq_22s_14s_step
  import cnn_sdiv_seq_22s_14s_pkg::*;
(
  input  logic [PREM_W-1:0] i_prem,
  input  logic              i_dbit,
  input  logic [DIN1_W-1:0] i_divisor,
  output logic [PREM_W-1:0] o_prem,
  output logic              o_qbit
);

  logic [PREM_W:0]   w_shift;
  logic [PREM_W-1:0] w_diff;

  assign w_shift = {i_prem, i_dbit};
  assign w_diff  = w_shift[PREM_W-1:0] - {1'b0, i_divisor};
  assign o_qbit  = (w_shift >= {2'b00, i_divisor});
  assign o_prem  = o_qbit ? w_diff : w_shift[PREM_W-1:0];

endmodule

// File: rtl/cnn_sdiv_seq_22s_14s.sv
// Sequential signed divider: 22-bit dividend / 14-bit divisor, C truncation,
// fixed 24-cycle latency from the accepting edge to ap_done.
module cnn_sdiv_seq_22s_14s
  import cnn_sdiv_seq_22s_14s_pkg::*;
#(
  parameter ID         = 32'd1,
  parameter din0_WIDTH = 32'd22,
  parameter din1_WIDTH = 32'd14,
  parameter dout_WIDTH = 32'd22
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  err
);

  state_e            r_state;
  logic [4:0]        r_cnt;
  logic [DIN0_W-1:0] r_quo;
  logic [PREM_W-1:0] r_prem;
  logic [DIN1_W-1:0] r_div;
  logic              r_sign0;
  logic              r_sign1;
  logic              r_div_zero;
  logic [DIN0_W-1:0] r_dout;
  logic [DIN1_W-1:0] r_rem;
  logic              r_err;

  logic [PREM_W-1:0] w_prem_next;
  logic              w_qbit;
  logic              w_qneg;
  logic              w_ovf;
  logic [DIN0_W-1:0] w_quo_s;
  logic [DIN1_W-1:0] w_rem_s;

  // r_quo starts as |din0| and shifts left, feeding dividend bits out and quotient bits in.
  cnn_sdiv_seq_22s_14s_step u_step (
    .i_prem    (r_prem),
    .i_dbit    (r_quo[DIN0_W-1]),
    .i_divisor (r_div),
    .o_prem    (w_prem_next),
    .o_qbit    (w_qbit)
  );

  assign w_qneg  = r_sign0 ^ r_sign1;
  // Only -2^21 / -1 yields a positive magnitude with the top bit set.
  assign w_ovf   = ~w_qneg & r_quo[DIN0_W-1] & ~r_prem[PREM_W-1];
  assign w_quo_s = cneg22(r_quo, w_qneg);
  assign w_rem_s = cneg14(r_prem[DIN1_W-1:0], r_sign0);

  assign ap_idle  = (r_state == ST_IDLE);
  assign ap_ready = ap_idle & ap_start & ap_rst_n;
  assign ap_done  = (r_state == ST_DONE);
  assign dout     = r_dout;
  assign rem      = r_rem;
  assign err      = r_err;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 5'd0;
      r_quo      <= 22'd0;
      r_prem     <= 15'd0;
      r_div      <= 14'd0;
      r_sign0    <= 1'b0;
      r_sign1    <= 1'b0;
      r_div_zero <= 1'b0;
      r_dout     <= 22'd0;
      r_rem      <= 14'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ap_start) begin
            r_quo      <= cneg22(din0, din0[DIN0_W-1]);
            r_div      <= cneg14(din1, din1[DIN1_W-1]);
            r_sign0    <= din0[DIN0_W-1];
            r_sign1    <= din1[DIN1_W-1];
            r_div_zero <= (din1 == 14'd0);
            r_prem     <= 15'd0;
            r_cnt      <= 5'd0;
            r_state    <= ST_CALC;
          end else begin
            r_state    <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_prem <= w_prem_next;
          r_quo  <= {r_quo[DIN0_W-2:0], w_qbit};
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == (ITERS - 5'd1)) begin
            r_state <= ST_FIX;
          end else begin
            r_state <= ST_CALC;
          end
        end
        ST_FIX: begin
          if (r_div_zero) begin
            r_dout <= 22'h3FFFFF;
            r_rem  <= 14'd0;
            r_err  <= 1'b1;
          end else if (w_ovf) begin
            r_dout <= 22'h1FFFFF;
            r_rem  <= 14'd0;
            r_err  <= 1'b1;
          end else begin
            r_dout <= w_quo_s;
            r_rem  <= w_rem_s;
            r_err  <= 1'b0;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cnn_sdiv_seq_22s_14s.md
CNN_SDIV_SEQ_22S_14S -- requirements
Module: cnn_sdiv_seq_22s_14s

Interface
REQ-001 The block SHALL expose parameter ID, default 32'd1, instance identifier with no functional effect.
REQ-002 The block SHALL expose parameter din0_WIDTH, default 32'd22, dividend width; only 22 is supported.
REQ-003 The block SHALL expose parameter din1_WIDTH, default 32'd14, divisor width; only 14 is supported.
REQ-004 The block SHALL expose parameter dout_WIDTH, default 32'd22, quotient width; only 22 is supported.
REQ-005 The block SHALL have port ap_clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-006 The block SHALL have port ap_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port ap_start, input, 1 bit, request to begin a division.
REQ-008 The block SHALL have port din0, input, 22 bits, signed dividend.
REQ-009 The block SHALL have port din1, input, 14 bits, signed divisor.
REQ-010 The block SHALL have port ap_idle, output, 1 bit, high while in IDLE.
REQ-011 The block SHALL have port ap_ready, output, 1 bit, one-cycle pulse when operands are accepted.
REQ-012 The block SHALL have port ap_done, output, 1 bit, one-cycle pulse when results are valid.
REQ-013 The block SHALL have port dout, output, 22 bits, signed quotient.
REQ-014 The block SHALL have port rem, output, 14 bits, signed remainder.
REQ-015 The block SHALL have port err, output, 1 bit, set for divide-by-zero or quotient overflow.

Function
REQ-016 The block SHALL compute dout = din0 / din1 and rem = din0 - dout*din1, truncating toward zero (C semantics), so rem takes the sign of the dividend.
REQ-017 The block SHALL use FSM states IDLE, CALC, FIX and DONE, with transitions IDLE->CALC on ap_start=1, CALC->FIX after 22 iterations, FIX->DONE, and DONE->IDLE.
REQ-018 In IDLE with ap_start=1, the block SHALL register din0 and din1 at the clock edge and assert ap_ready combinationally in that same cycle.
REQ-019 CALC SHALL perform one unsigned restoring-division step per cycle on the absolute values, MSB first, for exactly 22 cycles.
REQ-020 FIX SHALL apply the quotient sign (sign0 XOR sign1) and the remainder sign (sign0), then detect the error cases.
REQ-021 ap_done SHALL be high only in DONE, which occurs exactly 24 cycles after the accepting edge.
REQ-022 dout, rem and err SHALL be registered and SHALL be valid from the ap_done cycle, holding their values until the next ap_done.
REQ-023 ap_start SHALL be ignored in CALC, FIX and DONE; a new request is accepted only in IDLE, giving a minimum issue interval of 25 cycles.
REQ-024 When din1 = 0, the block SHALL return dout = 22'h3FFFFF (-1), rem = 0 and err = 1, with the same latency as a normal division.
REQ-025 When din0 = -2097152 and din1 = -1, the block SHALL saturate dout to 2097151, return rem = 0, and set err = 1.
REQ-026 In all other cases err SHALL be 0.
REQ-027 Internal magnitudes SHALL be held at 22 bits for the dividend and 14 bits for the divisor, with a 15-bit partial remainder so that |-8192| is represented without overflow.

Reset
REQ-028 On ap_rst_n = 0, the block SHALL immediately enter IDLE, with ap_idle = 1 and ap_ready = ap_done = 0.
REQ-029 On ap_rst_n = 0, dout, rem, err and all internal registers SHALL be cleared to 0.
REQ-030 A reset during CALC or FIX SHALL abort the operation without ever producing ap_done.

Structure
REQ-031 A shared package SHALL hold the width constants (22, 14), the iteration count (22), the latency (24) and the FSM state enum.
REQ-032 The block SHALL have one sub-module, cnn_sdiv_seq_22s_14s_step: a combinational single restoring iteration (partial remainder and divisor in; next remainder and quotient bit out).

Verification
REQ-033 The bench SHALL drive din0=1000, din1=7 and check dout=142, rem=6, err=0, with ap_done 24 cycles after ap_ready.
REQ-034 The bench SHALL drive din0=-1000, din1=7 and check dout=-142, rem=-6; then din0=1000, din1=-7 and check dout=-142, rem=6.
REQ-035 The bench SHALL drive din1=0 with din0=5 and check dout=-1, rem=0, err=1; then din0=-2097152, din1=-1 and check dout=2097151, err=1.
REQ-036 The bench SHALL hold ap_start high continuously and check that ap_ready pulses every 25 cycles and that operands changed mid-operation do not affect the result.
REQ-037 The bench SHALL assert ap_rst_n low 10 cycles into CALC and check no ap_done, all outputs 0, ap_idle=1; a following 100/10 SHALL return dout=10, rem=0.
